// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vga_timing_gen                                                   |
// | Purpose : 640x480@60 sync/DE/coordinate generator with a registered RGB    |
// |           output stage. Define VGA_TIMING_TEST_PATTERN_EN to replace       |
// |           rgb_in with 8 vertical colour bars.                              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   COLOR_W  = 4
) (
  input  logic                   clock_vga,
  input  logic                   reset,
  output logic [9:0]             pix_x,
  output logic [9:0]             pix_y,
  output logic                   pix_req,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [15:0]            frame_count,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_de,
  output logic [COLOR_W-1:0]     vga_r,
  output logic [COLOR_W-1:0]     vga_g,
  output logic [COLOR_W-1:0]     vga_b
);

  localparam int c_h_total = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int c_v_total = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last       = 10'(c_h_total - 1);
  localparam logic [9:0] c_h_active_end = 10'(H_ACTIVE - 1);
  localparam logic [9:0] c_h_front_end  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] c_h_sync_end   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] c_v_last       = 10'(c_v_total - 1);
  localparam logic [9:0] c_v_active_end = 10'(V_ACTIVE - 1);
  localparam logic [9:0] c_v_front_end  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] c_v_sync_end   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  if (c_h_total > 1024) begin : g_h_total_too_large
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (c_v_total > 1024) begin : g_v_total_too_large
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } region_t;

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  region_t    r_hstate;
  region_t    r_vstate;
  region_t    w_hstate_next;
  region_t    w_vstate_next;
  logic       w_hwrap;
  logic       w_vwrap;
  logic [3*COLOR_W-1:0] w_colour;

  assign w_hwrap = (r_hcnt == c_h_last);
  assign w_vwrap = (r_vcnt == c_v_last);

  always_ff @(posedge clock_vga) begin
    if (reset) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_hstate    <= ST_ACTIVE;
      r_vstate    <= ST_ACTIVE;
      frame_count <= '0;
    end else begin
      r_hcnt   <= w_hwrap ? '0 : r_hcnt + 10'd1;
      r_hstate <= w_hstate_next;
      r_vstate <= w_vstate_next;
      if (w_hwrap) begin
        r_vcnt <= w_vwrap ? '0 : r_vcnt + 10'd1;
      end
      if (w_hwrap && w_vwrap) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // States advance on the edge where the counter enters the next region.
  always_comb begin
    w_hstate_next = r_hstate;
    case (r_hstate)
      ST_ACTIVE: if (r_hcnt == c_h_active_end) w_hstate_next = ST_FRONT;
      ST_FRONT:  if (r_hcnt == c_h_front_end)  w_hstate_next = ST_SYNC;
      ST_SYNC:   if (r_hcnt == c_h_sync_end)   w_hstate_next = ST_BACK;
      ST_BACK:   if (w_hwrap)                  w_hstate_next = ST_ACTIVE;
      default:                                 w_hstate_next = ST_ACTIVE;
    endcase
  end

  always_comb begin
    w_vstate_next = r_vstate;
    if (w_hwrap) begin
      case (r_vstate)
        ST_ACTIVE: if (r_vcnt == c_v_active_end) w_vstate_next = ST_FRONT;
        ST_FRONT:  if (r_vcnt == c_v_front_end)  w_vstate_next = ST_SYNC;
        ST_SYNC:   if (r_vcnt == c_v_sync_end)   w_vstate_next = ST_BACK;
        ST_BACK:   if (w_vwrap)                  w_vstate_next = ST_ACTIVE;
        default:                                 w_vstate_next = ST_ACTIVE;
      endcase
    end
  end

  assign pix_x       = r_hcnt;
  assign pix_y       = r_vcnt;
  assign pix_req     = (r_hstate == ST_ACTIVE) && (r_vstate == ST_ACTIVE);
  assign line_start  = (r_hcnt == 10'd0);
  assign frame_start = (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam int c_bar_w = H_ACTIVE / 8;

  logic [9:0] w_bar_raw;
  logic [2:0] w_bar;
  logic [2:0] w_bar_rgb;
  logic       w_unused_rgb;

  assign w_unused_rgb = ^rgb_in;
  assign w_bar_raw    = r_hcnt / 10'(c_bar_w);
  assign w_bar        = (w_bar_raw > 10'd7) ? 3'd7 : w_bar_raw[2:0];

  // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    w_bar_rgb = 3'b000;
    case (w_bar)
      3'd0:    w_bar_rgb = 3'b111;
      3'd1:    w_bar_rgb = 3'b110;
      3'd2:    w_bar_rgb = 3'b011;
      3'd3:    w_bar_rgb = 3'b010;
      3'd4:    w_bar_rgb = 3'b101;
      3'd5:    w_bar_rgb = 3'b100;
      3'd6:    w_bar_rgb = 3'b001;
      default: w_bar_rgb = 3'b000;
    endcase
  end

  assign w_colour = {{COLOR_W{w_bar_rgb[2]}}, {COLOR_W{w_bar_rgb[1]}}, {COLOR_W{w_bar_rgb[0]}}};
`else
  assign w_colour = rgb_in;
`endif

  always_ff @(posedge clock_vga) begin
    if (reset) begin
      vga_de <= 1'b0;
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else begin
      vga_de <= pix_req;
      vga_hs <= (r_hstate == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga_vs <= (r_vstate == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
      vga_r  <= pix_req ? w_colour[3*COLOR_W-1 -: COLOR_W] : '0;
      vga_g  <= pix_req ? w_colour[2*COLOR_W-1 -: COLOR_W] : '0;
      vga_b  <= pix_req ? w_colour[COLOR_W-1 -: COLOR_W]   : '0;
    end
  end

`ifndef SYNTHESIS
  function automatic region_t f_region(input logic [9:0] cnt, input int act, input int fr,
                                       input int sy);
    if (int'(cnt) < act)           return ST_ACTIVE;
    if (int'(cnt) < act + fr)      return ST_FRONT;
    if (int'(cnt) < act + fr + sy) return ST_SYNC;
    return ST_BACK;
  endfunction

  always_ff @(posedge clock_vga) begin
    if (!reset) begin
      a_hstate_matches_hcnt: assert (r_hstate == f_region(r_hcnt, H_ACTIVE, H_FRONT, H_SYNC));
      a_vstate_matches_vcnt: assert (r_vstate == f_region(r_vcnt, V_ACTIVE, V_FRONT, V_SYNC));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vga_timing_gen                                                |
// | Purpose : table-driven check of vga_timing_gen with a shortened frame.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

  // Full 800-cycle lines, vertical timing shortened to 30 lines per frame.
  localparam int LINE  = 800;
  localparam int VTOT  = 30;
  localparam int FRAME = LINE * VTOT;
  localparam int NV    = 19;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_req;
  logic [11:0] rgb_in;
  logic        frame_start;
  logic        line_start;
  logic [15:0] frame_count;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_de;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;

  always #5 clk = ~clk;

  assign rgb_in = {pix_x[3:0], pix_y[3:0], 4'hA};

  vga_timing_gen #(
    .V_ACTIVE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
  ) dut (
    .clock_vga(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
    .rgb_in(rgb_in), .frame_start(frame_start), .line_start(line_start),
    .frame_count(frame_count), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // Cycles since reset release; equals the expected stage-0 position.
  int n = 0;
  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  task automatic wait_to(input int t);
    int guard;
    guard = 0;
    while (n < t && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_cycle", 32'(n), 32'(t));
  endtask

  // Background monitor of sync run lengths, line-0 counts and frame_start spacing.
  logic mon_on    = 1'b0;
  logic first_run = 1'b1;
  int hs_run = 0, hs_runs = 0, hs_bad = 0;
  int vs_run = 0, vs_runs = 0, vs_bad = 0;
  int hs_low_l0 = 0, de_l0 = 0, hs_first = -1;
  int vs_low_f0 = 0, vs_first = -1;
  int fs_last = 0, fs_pulses = 0, fs_bad = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_on) begin
        if (vga_hs === 1'b0) hs_run++;
        else if (hs_run != 0) begin
          hs_runs++;
          if (hs_run != 96) hs_bad++;
          hs_run = 0;
        end
        if (vga_vs === 1'b0) vs_run++;
        else if (vs_run != 0) begin
          vs_runs++;
          if (vs_run != 2 * LINE) vs_bad++;
          vs_run = 0;
        end
        if (first_run && !reset) begin
          if (n >= 1 && n <= LINE) begin
            if (vga_hs === 1'b0) begin
              hs_low_l0++;
              if (hs_first < 0) hs_first = n;
            end
            if (vga_de === 1'b1) de_l0++;
          end
          if (n >= 1 && n <= FRAME && vga_vs === 1'b0) begin
            vs_low_f0++;
            if (vs_first < 0) vs_first = n;
          end
          if (frame_start === 1'b1) begin
            if (fs_pulses > 0 && (n - fs_last) != FRAME) fs_bad++;
            fs_last = n;
            fs_pulses++;
          end
        end
      end
    end
  end

  typedef struct {
    int         h;
    int         v;
    logic       req, ls, fs;
    logic       de, hs, vs;
    logic [11:0] rgb;
    logic [11:0] rgb_tp;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    logic [11:0] exp_rgb;
    int          t;

    //           h    v  req ls fs  de hs vs  rgb      pattern
    tbl[0]  = '{   0,  0, 1, 1, 1,  1, 1, 1, 12'h00A, 12'hFFF};
    tbl[1]  = '{   1,  0, 1, 0, 0,  1, 1, 1, 12'h10A, 12'hFFF};
    tbl[2]  = '{  80,  0, 1, 0, 0,  1, 1, 1, 12'h00A, 12'hFF0};
    tbl[3]  = '{ 600,  0, 1, 0, 0,  1, 1, 1, 12'h80A, 12'h000};
    tbl[4]  = '{ 639,  0, 1, 0, 0,  1, 1, 1, 12'hF0A, 12'h000};
    tbl[5]  = '{ 640,  0, 0, 0, 0,  0, 1, 1, 12'h000, 12'h000};
    tbl[6]  = '{ 655,  0, 0, 0, 0,  0, 1, 1, 12'h000, 12'h000};
    tbl[7]  = '{ 656,  0, 0, 0, 0,  0, 0, 1, 12'h000, 12'h000};
    tbl[8]  = '{ 751,  0, 0, 0, 0,  0, 0, 1, 12'h000, 12'h000};
    tbl[9]  = '{ 752,  0, 0, 0, 0,  0, 1, 1, 12'h000, 12'h000};
    tbl[10] = '{ 799,  0, 0, 0, 0,  0, 1, 1, 12'h000, 12'h000};
    tbl[11] = '{   0,  1, 1, 1, 0,  1, 1, 1, 12'h01A, 12'hFFF};
    tbl[12] = '{ 700,  5, 0, 0, 0,  0, 0, 1, 12'h000, 12'h000};
    tbl[13] = '{   5, 19, 1, 0, 0,  1, 1, 1, 12'h53A, 12'hFFF};
    tbl[14] = '{   5, 20, 0, 0, 0,  0, 1, 1, 12'h000, 12'h000};
    tbl[15] = '{   0, 23, 0, 1, 0,  0, 1, 0, 12'h000, 12'h000};
    tbl[16] = '{ 799, 24, 0, 0, 0,  0, 1, 0, 12'h000, 12'h000};
    tbl[17] = '{   0, 25, 0, 1, 0,  0, 1, 1, 12'h000, 12'h000};
    tbl[18] = '{ 799, 29, 0, 0, 0,  0, 1, 1, 12'h000, 12'h000};

    // Reset held: outputs idle, counters parked at 0.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hs", 32'(vga_hs), 32'd1);
      check("rst_vs", 32'(vga_vs), 32'd1);
      check("rst_de", 32'(vga_de), 32'd0);
      check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
      check("rst_pix_x", 32'(pix_x), 32'd0);
      check("rst_fc", 32'(frame_count), 32'd0);
    end

    reset  = 1'b0;
    mon_on = 1'b1;
    check("rel_fs", 32'(frame_start), 32'd1);
    check("rel_pix_x", 32'(pix_x), 32'd0);
    check("rel_de_still_low", 32'(vga_de), 32'd0);

    for (int i = 0; i < NV; i++) begin
      t = tbl[i].v * LINE + tbl[i].h;
      wait_to(t);
      check("pix_x", 32'(pix_x), 32'(tbl[i].h));
      check("pix_y", 32'(pix_y), 32'(tbl[i].v));
      check("pix_req", 32'(pix_req), 32'(tbl[i].req));
      check("line_start", 32'(line_start), 32'(tbl[i].ls));
      check("frame_start", 32'(frame_start), 32'(tbl[i].fs));
      if (i == NV - 1) check("fc_before_wrap", 32'(frame_count), 32'd0);
      @(negedge clk);
      check("vga_de", 32'(vga_de), 32'(tbl[i].de));
      check("vga_hs", 32'(vga_hs), 32'(tbl[i].hs));
      check("vga_vs", 32'(vga_vs), 32'(tbl[i].vs));
`ifdef VGA_TIMING_TEST_PATTERN_EN
      exp_rgb = tbl[i].rgb_tp;
`else
      exp_rgb = tbl[i].rgb;
`endif
      check("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
    end

    // Frame boundary: h wrap, v wrap and frame_count step on the same edge.
    wait_to(FRAME);
    check("f1_fs", 32'(frame_start), 32'd1);
    check("f1_pix_y", 32'(pix_y), 32'd0);
    check("f1_fc", 32'(frame_count), 32'd1);
    wait_to(2 * FRAME);
    check("f2_fs", 32'(frame_start), 32'd1);
    check("f2_fc", 32'(frame_count), 32'd2);
    @(negedge clk);
    #2;
    check("fs_pulses", 32'(fs_pulses), 32'd3);
    check("fs_gap_bad", 32'(fs_bad), 32'd0);
    check("l0_hs_low", 32'(hs_low_l0), 32'd96);
    check("l0_hs_first", 32'(hs_first), 32'd657);
    check("l0_de_cnt", 32'(de_l0), 32'd640);
    check("f0_vs_low", 32'(vs_low_f0), 32'(2 * LINE));
    check("f0_vs_first", 32'(vs_first), 32'(23 * LINE + 1));

    // Mid-frame single-cycle reset at (300,10) of frame 2.
    wait_to(2 * FRAME + 10 * LINE + 300);
    check("mid_pix_x", 32'(pix_x), 32'd300);
    check("mid_pix_y", 32'(pix_y), 32'd10);
    first_run = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_pix_x", 32'(pix_x), 32'd0);
    check("mid_rst_pix_y", 32'(pix_y), 32'd0);
    check("mid_rst_fc", 32'(frame_count), 32'd0);
    check("mid_rst_hs", 32'(vga_hs), 32'd1);
    check("mid_rst_de", 32'(vga_de), 32'd0);
    check("mid_rst_fs", 32'(frame_start), 32'd1);
    @(negedge clk);
    check("mid_de", 32'(vga_de), 32'd1);
    check("mid_pix_x1", 32'(pix_x), 32'd1);
    wait_to(LINE + 1);
    #2;
    check("mid_fc_line", 32'(frame_count), 32'd0);
    check("hs_runs", 32'(hs_runs), 32'd71);
    check("hs_short_runs", 32'(hs_bad), 32'd0);
    check("vs_runs", 32'(vs_runs), 32'd2);
    check("vs_short_runs", 32'(vs_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Display timing stage that runs in the clock_vga domain, driven by the PLL's VGA output clock.
- Generates 640x480@60 horizontal and vertical sync, data-enable and pixel coordinates.
- Fetches colour from an upstream pixel source through a same-cycle request/response contract.
- Drives registered RGB and sync to the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
COLOR_W, 4, bits per colour channel

Ports:
clock_vga  input  1  pixel clock (25.175 MHz nominal); sole clock
reset  input  1  synchronous, active-high
pix_x  output  10  current column, 0..H_TOTAL-1
pix_y  output  10  current line, 0..V_TOTAL-1
pix_req  output  1  high when (pix_x,pix_y) is inside the active area
rgb_in  input  3*COLOR_W  {r,g,b} colour for the current pix_x/pix_y, valid same cycle as pix_req
frame_start  output  1  one-cycle pulse when pix_x=0 and pix_y=0
line_start  output  1  one-cycle pulse when pix_x=0
frame_count  output  16  completed-frame counter
vga_hs  output  1  horizontal sync
vga_vs  output  1  vertical sync
vga_de  output  1  data enable
vga_r, vga_g, vga_b  output  COLOR_W each  pixel colour

Behaviour:
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be at most 1024; elaboration fails otherwise.
- Stage 0 (counters):
  - hcnt increments every cycle; at H_TOTAL-1 it wraps to 0.
  - vcnt increments only on an hcnt wrap; at V_TOTAL-1 (coinciding with the hcnt wrap) it wraps to 0.
  - pix_x/pix_y are the counter registers, driven directly.
- Per-axis region FSM, states ACTIVE, FRONT, SYNC, BACK:
  - H transitions: ACTIVE->FRONT at hcnt=H_ACTIVE, FRONT->SYNC at H_ACTIVE+H_FRONT, SYNC->BACK at H_ACTIVE+H_FRONT+H_SYNC, BACK->ACTIVE on wrap.
  - V uses the same structure, with transitions evaluated only on the hcnt wrap.
  - The state must always equal the state decoded from the counter; it is checked by assertion.
- Stage 0 decoded signals:
  - pix_req = hstate==ACTIVE && vstate==ACTIVE.
  - line_start = hcnt==0; frame_start = hcnt==0 && vcnt==0. Both are decoded from the registered counters, so each is a single-cycle pulse.
- frame_count increments on the final cycle of each frame (the cycle where both counters wrap) and wraps from 0xFFFF to 0.
- Stage 1 (output register), fixed 1-cycle latency from stage 0:
  - vga_de <= pix_req.
  - vga_hs <= (hstate==SYNC) ? SYNC_POL : ~SYNC_POL; vga_vs is the same using vstate.
  - vga_r/g/b <= pix_req ? colour source : 0. Blanking forces 0 regardless of rgb_in.
- Upstream contract:
  - rgb_in is sampled at the clock edge that ends the cycle in which pix_req is high.
  - Upstream must derive rgb_in combinationally or from registers that are already valid for that pix_x/pix_y; no backpressure exists.
- Reset (synchronous, any time, including mid-line or mid-frame):
  - Reset values: hcnt=0, vcnt=0, both FSMs=ACTIVE, frame_count=0, vga_de=0, rgb outputs=0, vga_hs=vga_vs=~SYNC_POL.
  - While reset is held, the counters stay at 0.
  - First cycle after release: pix_x=0, pix_y=0, pix_req=1, frame_start=1, line_start=1.
  - First stage-1 output appears one cycle after release.
- Simultaneous events: at the frame-end cycle the h wrap, v wrap and frame_count increment all occur on the same edge.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined:
  - rgb_in is ignored; colour is 8 vertical bars of width H_ACTIVE/8, each channel all-ones or zero.
  - Order left to right: white, yellow, cyan, green, magenta, red, blue, black.
  - The bar index is pix_x / (H_ACTIVE/8), clamped to 7.
  - Blanking still forces 0, and pix_req still toggles.
- Undefined: colour = rgb_in as specified above.

Test Plan:
- Reset held 5 cycles, then released -> during reset vga_hs=vga_vs=1, vga_de=0, rgb=0; cycle after release frame_start=1, pix_x=0; next cycle vga_de=1.
- Free-run one line -> vga_hs low for exactly 96 consecutive cycles; first low cycle is one cycle after pix_x=656; vga_de high for 640 cycles per active line.
- Free-run two frames -> frame_start pulses exactly 420000 cycles apart; vga_vs low only while the stage-0 line is 490 or 491 (1600 cycles, offset +1); frame_count 0->1->2.
- rgb_in = {pix_x[3:0], pix_y[3:0], 4'hA} -> vga_r/g/b equal that value, delayed one cycle, during vga_de; outputs are 0 when pix_x=700 or pix_y=500.
- Reset asserted at pix_x=300, pix_y=200 for 1 cycle -> counters restart at 0,0; frame_count=0; no sync glitch shorter than a full sync width appears.
- With VGA_TIMING_TEST_PATTERN_EN defined -> output at pix_x=80 is yellow (F,F,0), at pix_x=600 is black, at pix_x=0 is white; rgb_in toggling has no effect.
